// File: rtl/cnn_layer_accel_weight_sequence_gen.sv
// Weight sequence generator: steps (gray_code, sequence_selector, seq_data_addr)
// through cfg_num_passes passes of SEQ_LEN entries for the weight sequence table.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | presenting entries; one entry consumed per seq_valid & advance
// DONE  | one-cycle completion pulse, returns to IDLE
module cnn_layer_accel_weight_sequence_gen #(
  parameter int SEQ_LEN = 5,
  parameter int PASS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] cfg_num_passes,
  input  logic              cfg_sel_init,
  input  logic              advance,
  output logic [1:0]        gray_code,
  output logic              sequence_selector,
  output logic [2:0]        seq_data_addr,
  output logic              seq_valid,
  output logic              wht_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST_ADDR = 3'(SEQ_LEN - 1);

  state_t            state, state_nxt;
  logic [PASS_W-1:0] pass_cnt, pass_cnt_nxt;
  logic [PASS_W-1:0] num_passes, num_passes_nxt;
  logic [1:0]        gray_nxt;
  logic              sel_nxt;
  logic [2:0]        addr_nxt;
  logic              consume;
  logic              last_pass;

  assign seq_valid = (state == RUN);
  assign done      = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign consume   = seq_valid && advance;
  assign last_pass = (pass_cnt + PASS_W'(1)) == num_passes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pass_cnt_nxt   = pass_cnt;
    num_passes_nxt = num_passes;
    gray_nxt       = gray_code;
    sel_nxt        = sequence_selector;
    addr_nxt       = seq_data_addr;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_num_passes != '0) begin
            state_nxt      = RUN;
            num_passes_nxt = cfg_num_passes;
            pass_cnt_nxt   = '0;
            gray_nxt       = 2'b00;
            sel_nxt        = cfg_sel_init;
            addr_nxt       = 3'd0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (consume) begin
          if (seq_data_addr != LAST_ADDR) begin
            addr_nxt = seq_data_addr + 3'd1;
          end else if (last_pass) begin
            state_nxt = DONE;
          end else begin
            addr_nxt     = 3'd0;
            pass_cnt_nxt = pass_cnt + PASS_W'(1);
            // 00->01->11->10->00; selector flips when the cycle of four closes
            gray_nxt     = {gray_code[0], ~gray_code[1]};
            if (gray_code == 2'b10) sel_nxt = ~sequence_selector;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt          <= '0;
      num_passes        <= '0;
      gray_code         <= 2'b00;
      sequence_selector <= 1'b0;
      seq_data_addr     <= 3'd0;
      wht_valid         <= 1'b0;
    end else begin
      pass_cnt          <= pass_cnt_nxt;
      num_passes        <= num_passes_nxt;
      gray_code         <= gray_nxt;
      sequence_selector <= sel_nxt;
      seq_data_addr     <= addr_nxt;
      wht_valid         <= consume;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_gen.sv
// Randomized self-checking bench for the weight sequence generator against a
// per-entry expected-sequence model built from pass/entry arithmetic.
module tb_cnn_layer_accel_weight_sequence_gen;
  localparam int SEQ_LEN = 5;
  localparam int PASS_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [PASS_W-1:0] cfg_num_passes = '0;
  logic              cfg_sel_init = 1'b0;
  logic              advance = 1'b0;
  logic [1:0]        gray_code;
  logic              sequence_selector;
  logic [2:0]        seq_data_addr;
  logic              seq_valid;
  logic              wht_valid;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  cnn_layer_accel_weight_sequence_gen #(.SEQ_LEN(SEQ_LEN), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_passes(cfg_num_passes), .cfg_sel_init(cfg_sel_init), .advance(advance),
    .gray_code(gray_code), .sequence_selector(sequence_selector),
    .seq_data_addr(seq_data_addr), .seq_valid(seq_valid), .wht_valid(wht_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // mode: 0 advance always 1, 1 random advance plus start/cfg noise, 2 advance pattern 1,0,0,1
  task automatic run_check(input int n, input logic sel, input int mode, input logic with_abort,
                           input string name);
    logic [5:0] exp_q[$];
    logic [5:0] got;
    logic       prev_c;
    int         cyc;
    for (int p = 0; p < n; p++)
      for (int a = 0; a < SEQ_LEN; a++)
        exp_q.push_back({gray_tab[p % 4], sel ^ 1'((p / 4) % 2), 3'(a)});
    start = 1'b1; abort = with_abort; cfg_num_passes = PASS_W'(n);
    cfg_sel_init = sel; advance = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    if (n == 0) begin
      n_checks++;
      if (done !== 1'b1 || seq_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s zero_pass_done: got done=%b valid=%b busy=%b, want 1 0 1",
                 name, done, seq_valid, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || seq_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s zero_pass_idle: got done=%b valid=%b busy=%b, want 0 0 0",
                 name, done, seq_valid, busy);
      end
      return;
    end
    prev_c = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      case (mode)
        0: advance = 1'b1;
        1: begin
          advance = 1'($urandom_range(0, 1));
          start = 1'($urandom_range(0, 1));
          cfg_num_passes = PASS_W'($urandom);
          cfg_sel_init = 1'($urandom_range(0, 1));
        end
        default: advance = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      got = {gray_code, sequence_selector, seq_data_addr};
      n_checks++;
      if (seq_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s entry cyc %0d: got valid=%b busy=%b done=%b gray/sel/addr=%b, want 1 1 0 %b",
                 name, cyc, seq_valid, busy, done, got, exp_q[0]);
      end
      n_checks++;
      if (wht_valid !== prev_c) begin
        n_fail++;
        $display("FAIL %s wht_valid cyc %0d: got %b, want %b", name, cyc, wht_valid, prev_c);
      end
      if (advance) void'(exp_q.pop_front());
      prev_c = advance;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; advance = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d entries left, want 0", name, exp_q.size());
    end
    n_checks++;
    if (done !== 1'b1 || seq_valid !== 1'b0 || busy !== 1'b1 || wht_valid !== prev_c) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done=%b valid=%b busy=%b wht=%b, want 1 0 1 %b",
               name, done, seq_valid, busy, wht_valid, prev_c);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wht_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s back_idle: got done=%b busy=%b wht=%b, want 0 0 0",
               name, done, busy, wht_valid);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({gray_code, sequence_selector, seq_data_addr} !== 6'b0 || seq_valid !== 1'b0 ||
        wht_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got g=%b s=%b a=%0d v=%b w=%b b=%b d=%b, want all 0",
               gray_code, sequence_selector, seq_data_addr, seq_valid, wht_valid, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_abort();
    start = 1'b1; cfg_num_passes = PASS_W'(3); cfg_sel_init = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; advance = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({gray_code, sequence_selector, seq_data_addr} !== {2'b01, 1'b1, 3'd2} || seq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got valid=%b g/s/a=%b, want 1 011010", seq_valid,
               {gray_code, sequence_selector, seq_data_addr});
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; advance = 1'b0;
    n_checks++;
    if ({gray_code, sequence_selector, seq_data_addr} !== {2'b01, 1'b1, 3'd2} || seq_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || wht_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_post: got g/s/a=%b v=%b b=%b d=%b w=%b, want 011010 0 0 0 1",
               {gray_code, sequence_selector, seq_data_addr}, seq_valid, busy, done, wht_valid);
    end
    run_check(2, 1'b0, 0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; cfg_num_passes = PASS_W'(1); cfg_sel_init = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; advance = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (seq_data_addr !== 3'd3 || sequence_selector !== 1'b1 || wht_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got addr=%0d sel=%b wht=%b, want 3 1 1",
               seq_data_addr, sequence_selector, wht_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({gray_code, sequence_selector, seq_data_addr} !== 6'b0 || seq_valid !== 1'b0 ||
        wht_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got g=%b s=%b a=%0d v=%b w=%b b=%b d=%b, want all 0",
               gray_code, sequence_selector, seq_data_addr, seq_valid, wht_valid, busy, done);
    end
    advance = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_hold: got done=%b busy=%b, want 0 0", done, busy);
    end
    rst = 1'b1;
    run_check(1, 1'b1, 0, 1'b0, "after_reset");
  endtask

  initial begin
    #12;
    test_reset();
    run_check(2, 1'b1, 0, 1'b0, "two_pass");
    run_check(5, 1'b0, 0, 1'b0, "five_pass");
    run_check(1, 1'b0, 2, 1'b0, "adv_pattern");
    run_check(0, 1'b0, 0, 1'b0, "zero_pass");
    run_check(3, 1'b1, 1, 1'b1, "start_with_abort");
    test_abort();
    test_reset_mid_run();
    for (int i = 0; i < 6; i++)
      run_check(int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)), 1,
                1'($urandom_range(0, 1)), "random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
